delay_meas: RTL and testbench



---
 rtl/delay_meas.sv | 126 ++++++++++++
 tb/tb_delay_meas.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/delay_meas.sv
// Measures the rise-to-rise delay between a reference signal and its delayed copy,
// plus the high width of the delayed pulse, both in clock cycles.
module delay_meas #(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 200
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_in,
    input  logic             stop_in,
    output logic [CNT_W-1:0] delay_cnt,
    output logic [CNT_W-1:0] width_cnt,
    output logic             done,
    output logic             timeout,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_STOP = 2'd1,
        WIDTH     = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] delay_q, delay_d;
    logic [CNT_W-1:0] width_q, width_d;
    logic             done_q, done_d;
    logic             timeout_q, timeout_d;
    logic             busy_q, busy_d;
    logic             start_prev_q;
    logic             stop_prev_q;

    logic start_rise, stop_rise, stop_fall;

    assign start_rise = start_in & ~start_prev_q;
    assign stop_rise  = stop_in & ~stop_prev_q;
    assign stop_fall  = ~stop_in & stop_prev_q;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
        state_d   = state_q;
        cnt_d     = cnt_q;
        delay_d   = delay_q;
        width_d   = width_q;
        done_d    = 1'b0;
        timeout_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_rise) begin
                    cnt_d = ONE_C;
                    if (stop_rise) begin
                        delay_d = '0;
                        state_d = WIDTH;
                    end else begin
                        state_d = WAIT_STOP;
                    end
                end
            end
            WAIT_STOP: begin
                // Later start edges are ignored: the delay is anchored to the first one.
                if (stop_rise) begin
                    delay_d = cnt_q;
                    cnt_d   = ONE_C;
                    state_d = WIDTH;
                end else if (cnt_q == TIMEOUT_C) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + ONE_C;
                end
            end
            WIDTH: begin
                if (stop_fall) begin
                    width_d = cnt_q;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q == TIMEOUT_C) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + ONE_C;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            delay_q      <= '0;
            width_q      <= '0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
            busy_q       <= 1'b0;
            start_prev_q <= 1'b0;
            stop_prev_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            delay_q      <= delay_d;
            width_q      <= width_d;
            done_q       <= done_d;
            timeout_q    <= timeout_d;
            busy_q       <= busy_d;
            start_prev_q <= start_in;
            stop_prev_q  <= stop_in;
        end
    end

    assign delay_cnt = delay_q;
    assign width_cnt = width_q;
    assign done      = done_q;
    assign timeout   = timeout_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_delay_meas.sv
// Directed testbench for delay_meas with TIMEOUT=10; each scenario task drives
// per-cycle input vectors and compares {busy, done, timeout} plus the results.
module tb_delay_meas;

    localparam int CNT_W   = 8;
    localparam int TIMEOUT = 10;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start_in = 1'b0;
    logic             stop_in = 1'b0;
    logic [CNT_W-1:0] delay_cnt;
    logic [CNT_W-1:0] width_cnt;
    logic             done;
    logic             timeout;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;

    delay_meas #(
        .CNT_W  (CNT_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start_in (start_in),
        .stop_in  (stop_in),
        .delay_cnt(delay_cnt),
        .width_cnt(width_cnt),
        .done     (done),
        .timeout  (timeout),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Apply inputs for one edge, then settle 1 time unit past the edge.
    task automatic drive(input logic s, input logic t);
        start_in = s;
        stop_in  = t;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b1);
        n_checks++;
        if ({delay_cnt, width_cnt, busy, done, timeout} !== {8'd0, 8'd0, 3'b000}) begin
            n_fail++;
            $display("FAIL reset_outputs: got d=%0d w=%0d bdt=%b%b%b, want d=0 w=0 bdt=000",
                     delay_cnt, width_cnt, busy, done, timeout);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0);
            n_checks++;
            if (busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_release_busy step %0d: got %b want 0", i, busy);
            end
        end
    endtask

    task automatic test_stop_only();
        logic t[5] = '{0, 1, 1, 0, 0};
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, t[i]);
            n_checks++;
            if ({busy, done, timeout} !== 3'b000) begin
                n_fail++;
                $display("FAIL stop_only bdt step %0d: got %b%b%b want 000", i, busy, done, timeout);
            end
        end
        n_checks++;
        if ({delay_cnt, width_cnt} !== 16'h0000) begin
            n_fail++;
            $display("FAIL stop_only results: got d=%0d w=%0d want d=0 w=0", delay_cnt, width_cnt);
        end
    endtask

    task automatic test_nominal();
        logic       s[7] = '{1, 1, 0, 0, 0, 0, 0};
        logic       t[7] = '{0, 0, 0, 1, 1, 0, 0};
        logic [2:0] e[7] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b010, 3'b000};
        for (int i = 0; i < 7; i++) begin
            drive(s[i], t[i]);
            n_checks++;
            if ({busy, done, timeout} !== e[i]) begin
                n_fail++;
                $display("FAIL nominal bdt step %0d: got %b%b%b want %b", i, busy, done, timeout, e[i]);
            end
        end
        n_checks++;
        if (delay_cnt !== 8'd3 || width_cnt !== 8'd2) begin
            n_fail++;
            $display("FAIL nominal results: got d=%0d w=%0d want d=3 w=2", delay_cnt, width_cnt);
        end
    endtask

    task automatic test_zero_delay();
        logic       s[7] = '{1, 0, 0, 0, 0, 0, 0};
        logic       t[7] = '{1, 1, 1, 1, 1, 0, 0};
        logic [2:0] e[7] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b010, 3'b000};
        for (int i = 0; i < 7; i++) begin
            drive(s[i], t[i]);
            n_checks++;
            if ({busy, done, timeout} !== e[i]) begin
                n_fail++;
                $display("FAIL zero_delay bdt step %0d: got %b%b%b want %b", i, busy, done, timeout, e[i]);
            end
        end
        n_checks++;
        if (delay_cnt !== 8'd0 || width_cnt !== 8'd5) begin
            n_fail++;
            $display("FAIL zero_delay results: got d=%0d w=%0d want d=0 w=5", delay_cnt, width_cnt);
        end
    endtask

    task automatic test_timeout_wait();
        logic [2:0] e;
        for (int i = 0; i < 12; i++) begin
            drive(i == 0, 1'b0);
            e = (i < 10) ? 3'b100 : (i == 10) ? 3'b001 : 3'b000;
            n_checks++;
            if ({busy, done, timeout} !== e) begin
                n_fail++;
                $display("FAIL timeout_wait bdt step %0d: got %b%b%b want %b", i, busy, done, timeout, e);
            end
        end
        n_checks++;
        if (delay_cnt !== 8'd0 || width_cnt !== 8'd5) begin
            n_fail++;
            $display("FAIL timeout_wait results: got d=%0d w=%0d want d=0 w=5", delay_cnt, width_cnt);
        end
    endtask

    task automatic test_timeout_width();
        logic [2:0] e;
        for (int i = 0; i < 17; i++) begin
            drive(i == 0, (i >= 4) && (i <= 15));
            e = (i < 14) ? 3'b100 : (i == 14) ? 3'b001 : 3'b000;
            n_checks++;
            if ({busy, done, timeout} !== e) begin
                n_fail++;
                $display("FAIL timeout_width bdt step %0d: got %b%b%b want %b", i, busy, done, timeout, e);
            end
        end
        n_checks++;
        if (delay_cnt !== 8'd4 || width_cnt !== 8'd5) begin
            n_fail++;
            $display("FAIL timeout_width results: got d=%0d w=%0d want d=4 w=5", delay_cnt, width_cnt);
        end
    endtask

    task automatic test_second_start();
        logic       s[10] = '{1, 0, 1, 1, 0, 0, 0, 0, 0, 0};
        logic       t[10] = '{0, 0, 0, 0, 0, 1, 1, 1, 0, 0};
        logic [2:0] e;
        for (int i = 0; i < 10; i++) begin
            drive(s[i], t[i]);
            e = (i < 8) ? 3'b100 : (i == 8) ? 3'b010 : 3'b000;
            n_checks++;
            if ({busy, done, timeout} !== e) begin
                n_fail++;
                $display("FAIL second_start bdt step %0d: got %b%b%b want %b", i, busy, done, timeout, e);
            end
        end
        n_checks++;
        if (delay_cnt !== 8'd5 || width_cnt !== 8'd3) begin
            n_fail++;
            $display("FAIL second_start results: got d=%0d w=%0d want d=5 w=3", delay_cnt, width_cnt);
        end
    endtask

    task automatic test_reset_mid();
        logic s[4] = '{1, 0, 0, 0};
        logic t[4] = '{0, 0, 1, 1};
        for (int i = 0; i < 4; i++) begin
            drive(s[i], t[i]);
        end
        n_checks++;
        if (busy !== 1'b1 || delay_cnt !== 8'd2) begin
            n_fail++;
            $display("FAIL reset_mid pre: got busy=%b d=%0d want busy=1 d=2", busy, delay_cnt);
        end
        rst = 1'b1;
        drive(1'b0, 1'b1);
        rst = 1'b0;
        n_checks++;
        if ({delay_cnt, width_cnt, busy, done, timeout} !== {8'd0, 8'd0, 3'b000}) begin
            n_fail++;
            $display("FAIL reset_mid clear: got d=%0d w=%0d bdt=%b%b%b want d=0 w=0 bdt=000",
                     delay_cnt, width_cnt, busy, done, timeout);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, i == 0);
            n_checks++;
            if ({busy, done, timeout} !== 3'b000) begin
                n_fail++;
                $display("FAIL reset_mid after step %0d: got %b%b%b want 000", i, busy, done, timeout);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] e;
        for (int i = 0; i < 17; i++) begin
            drive((i == 0) || (i == 5), (i == 2) || (i == 3) || ((i >= 11) && (i <= 14)));
            e = (i == 4 || i == 15) ? 3'b010 : (i == 16) ? 3'b000 : 3'b100;
            n_checks++;
            if ({busy, done, timeout} !== e) begin
                n_fail++;
                $display("FAIL back_to_back bdt step %0d: got %b%b%b want %b", i, busy, done, timeout, e);
            end
            if (i == 4) begin
                n_checks++;
                if (delay_cnt !== 8'd2 || width_cnt !== 8'd2) begin
                    n_fail++;
                    $display("FAIL back_to_back first: got d=%0d w=%0d want d=2 w=2", delay_cnt, width_cnt);
                end
            end
        end
        n_checks++;
        if (delay_cnt !== 8'd6 || width_cnt !== 8'd4) begin
            n_fail++;
            $display("FAIL back_to_back second: got d=%0d w=%0d want d=6 w=4", delay_cnt, width_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_stop_only();
        test_nominal();
        test_zero_delay();
        test_timeout_wait();
        test_timeout_width();
        test_second_start();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
